// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud-mode config, FWFT byte FIFO, error/overrun/idle status
module uart_rx_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     SCLK,
    input  logic                     SCLR,
    input  logic                     CFG_WE,
    input  logic [1:0]               CFG_MODE,
    output logic [1:0]               MODE,
    output logic                     RX_CLR,
    input  logic                     RX_BUSY,
    input  logic                     RX_STB,
    input  logic [7:0]               RX_BYTE,
    input  logic                     RX_ERR,
    output logic [7:0]               DOUT,
    output logic                     DVALID,
    input  logic                     DREADY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     OVERRUN,
    output logic [7:0]               ERR_CNT,
    output logic                     IDLE_TO,
    input  logic                     CLR_STAT
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     cfg_latch;
    logic           req_hold;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_next;

    logic [CW-1:0]  idle_cnt;
    logic           armed;

    logic           stb_ok;
    logic           good;
    logic           bad;
    logic           pop;
    logic           full;
    logic           push;
    logic           drop;

    // Frames completing while the receiver is being cleared are meaningless
    assign stb_ok  = RX_STB && (state != APPLY);
    assign good    = stb_ok && !RX_ERR;
    assign bad     = stb_ok && RX_ERR;
    assign pop     = DVALID && DREADY;
    assign full    = (LEVEL == LW'(DEPTH));
    assign push    = good && (!full || pop);
    assign drop    = good && full && !pop;
    assign rd_next = rd_ptr + AW'(1);

    // Config FSM: hold mode changes until the receiver is between frames
    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            state     <= RUN;
            cfg_latch <= 2'd0;
            req_hold  <= 1'b0;
            MODE      <= 2'd0;
            RX_CLR    <= 1'b0;
        end else begin
            RX_CLR <= 1'b0;
            case (state)
                RUN: begin
                    if (CFG_WE || req_hold) begin
                        if (CFG_WE) begin
                            cfg_latch <= CFG_MODE;
                        end
                        req_hold <= 1'b0;
                        state    <= RX_BUSY ? PEND : APPLY;
                    end
                end
                PEND: begin
                    if (CFG_WE) begin
                        cfg_latch <= CFG_MODE;
                    end
                    if (!RX_BUSY) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    MODE   <= cfg_latch;
                    RX_CLR <= 1'b1;
                    state  <= RUN;
                    // A request arriving now is replayed from RUN next cycle
                    if (CFG_WE) begin
                        cfg_latch <= CFG_MODE;
                        req_hold  <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge SCLK) begin
        if (push) begin
            mem[wr_ptr] <= RX_BYTE;
        end
    end

    // FIFO pointers, occupancy and registered head (DOUT/DVALID)
    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            LEVEL  <= '0;
            DOUT   <= 8'd0;
            DVALID <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   LEVEL <= LEVEL + LW'(1);
                2'b01:   LEVEL <= LEVEL - LW'(1);
                default: LEVEL <= LEVEL;
            endcase
            // Head is loaded from entries already stored, so a fresh byte
            // becomes visible one edge after it was written
            if (pop) begin
                DVALID <= (LEVEL > LW'(1));
                if (LEVEL > LW'(1)) begin
                    DOUT <= mem[rd_next];
                end
            end else begin
                DVALID <= (LEVEL != '0);
                if (LEVEL != '0) begin
                    DOUT <= mem[rd_ptr];
                end
            end
        end
    end

    // Status: clear-then-event ordering so a coincident event survives CLR_STAT
    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            ERR_CNT <= 8'd0;
            OVERRUN <= 1'b0;
        end else begin
            if (bad) begin
                if (CLR_STAT) begin
                    ERR_CNT <= 8'd1;
                end else if (ERR_CNT != 8'hFF) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end else if (CLR_STAT) begin
                ERR_CNT <= 8'd0;
            end
            if (drop) begin
                OVERRUN <= 1'b1;
            end else if (CLR_STAT) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    // Idle timer: armed by a push, fires once, then parks until the next push
    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            idle_cnt <= '0;
            armed    <= 1'b0;
            IDLE_TO  <= 1'b0;
        end else begin
            IDLE_TO <= 1'b0;
            if (push) begin
                idle_cnt <= '0;
                armed    <= 1'b1;
            end else if (armed && !RX_BUSY && !RX_STB) begin
                idle_cnt <= idle_cnt + CW'(1);
                if (idle_cnt == CW'(TIMEOUT - 2)) begin
                    IDLE_TO <= 1'b1;
                    armed   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       SCLK = 1'b0;
    logic       SCLR;
    logic       CFG_WE;
    logic [1:0] CFG_MODE;
    logic [1:0] MODE;
    logic       RX_CLR;
    logic       RX_BUSY;
    logic       RX_STB;
    logic [7:0] RX_BYTE;
    logic       RX_ERR;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       DREADY;
    logic [3:0] LEVEL;
    logic       OVERRUN;
    logic [7:0] ERR_CNT;
    logic       IDLE_TO;
    logic       CLR_STAT;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .SCLK(SCLK), .SCLR(SCLR), .CFG_WE(CFG_WE), .CFG_MODE(CFG_MODE),
        .MODE(MODE), .RX_CLR(RX_CLR), .RX_BUSY(RX_BUSY), .RX_STB(RX_STB),
        .RX_BYTE(RX_BYTE), .RX_ERR(RX_ERR), .DOUT(DOUT), .DVALID(DVALID),
        .DREADY(DREADY), .LEVEL(LEVEL), .OVERRUN(OVERRUN), .ERR_CNT(ERR_CNT),
        .IDLE_TO(IDLE_TO), .CLR_STAT(CLR_STAT)
    );

    always #5 SCLK = ~SCLK;

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic e);
        RX_STB  = 1'b1;
        RX_BYTE = b;
        RX_ERR  = e;
        tick();
        RX_STB  = 1'b0;
        RX_ERR  = 1'b0;
    endtask

    task automatic do_reset();
        SCLR = 1'b1;
        tick();
        SCLR = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_mode"},    32'(MODE),    32'd0);
        chk({pfx, "_rx_clr"},  32'(RX_CLR),  32'd0);
        chk({pfx, "_dout"},    32'(DOUT),    32'd0);
        chk({pfx, "_dvalid"},  32'(DVALID),  32'd0);
        chk({pfx, "_level"},   32'(LEVEL),   32'd0);
        chk({pfx, "_overrun"}, 32'(OVERRUN), 32'd0);
        chk({pfx, "_err_cnt"}, 32'(ERR_CNT), 32'd0);
        chk({pfx, "_idle_to"}, 32'(IDLE_TO), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        int pulses;
        int first_at;

        SCLR = 1'b0; CFG_WE = 1'b0; CFG_MODE = 2'd0; RX_BUSY = 1'b0;
        RX_STB = 1'b0; RX_BYTE = 8'd0; RX_ERR = 1'b0; DREADY = 1'b0; CLR_STAT = 1'b0;
        #2;
        do_reset();
        chk_reset_vals("reset");

        // Three bytes held, then drained in order
        push(8'hA5, 1'b0);
        push(8'h3C, 1'b0);
        push(8'hFF, 1'b0);
        chk("fill3_level", 32'(LEVEL), 32'd3);
        chk("fill3_dvalid", 32'(DVALID), 32'd1);
        chk("fill3_dout", 32'(DOUT), 32'hA5);
        tick();
        chk("hold_dout", 32'(DOUT), 32'hA5);
        DREADY = 1'b1;
        tick();
        chk("pop1_dout", 32'(DOUT), 32'h3C);
        chk("pop1_level", 32'(LEVEL), 32'd2);
        tick();
        chk("pop2_dout", 32'(DOUT), 32'hFF);
        tick();
        chk("drain_dvalid", 32'(DVALID), 32'd0);
        chk("drain_level", 32'(LEVEL), 32'd0);
        DREADY = 1'b0;

        // Overrun on a full FIFO, then simultaneous push/pop at full
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
        chk("full_level", 32'(LEVEL), 32'd8);
        push(8'h55, 1'b0);
        chk("ovr_flag", 32'(OVERRUN), 32'd1);
        chk("ovr_level", 32'(LEVEL), 32'd8);
        CLR_STAT = 1'b1;
        push(8'h66, 1'b0);
        chk("ovr_clr_same_cycle", 32'(OVERRUN), 32'd1);
        tick();
        CLR_STAT = 1'b0;
        chk("ovr_cleared", 32'(OVERRUN), 32'd0);
        DREADY = 1'b1;
        push(8'h55, 1'b0);
        chk("fullpop_level", 32'(LEVEL), 32'd8);
        chk("fullpop_overrun", 32'(OVERRUN), 32'd0);
        exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("order_%0d", i), 32'(DOUT), 32'(exp_seq[i]));
            tick();
        end
        chk("order_empty", 32'(DVALID), 32'd0);
        DREADY = 1'b0;

        // Framing error counting and saturation
        do_reset();
        for (int i = 0; i < 256; i++) push(8'(i), 1'b1);
        chk("err_sat", 32'(ERR_CNT), 32'd255);
        chk("err_level", 32'(LEVEL), 32'd0);
        chk("err_dvalid", 32'(DVALID), 32'd0);
        CLR_STAT = 1'b1;
        push(8'h00, 1'b1);
        CLR_STAT = 1'b0;
        chk("err_clr_same_cycle", 32'(ERR_CNT), 32'd1);

        // Config held while busy; last request wins
        do_reset();
        RX_BUSY = 1'b1;
        CFG_WE = 1'b1; CFG_MODE = 2'd2;
        tick();
        CFG_WE = 1'b0;
        tick(); tick();
        chk("busy_mode_a", 32'(MODE), 32'd0);
        chk("busy_clr_a", 32'(RX_CLR), 32'd0);
        CFG_WE = 1'b1; CFG_MODE = 2'd3;
        tick();
        CFG_WE = 1'b0;
        tick();
        chk("busy_mode_b", 32'(MODE), 32'd0);
        RX_BUSY = 1'b0;
        tick();
        chk("pend_apply_mode", 32'(MODE), 32'd0);
        chk("pend_apply_clr", 32'(RX_CLR), 32'd0);
        tick();
        chk("applied_mode", 32'(MODE), 32'd3);
        chk("applied_clr", 32'(RX_CLR), 32'd1);
        tick();
        chk("clr_single", 32'(RX_CLR), 32'd0);
        chk("mode_kept", 32'(MODE), 32'd3);
        // Idle request; a frame strobe during APPLY is dropped
        CFG_WE = 1'b1; CFG_MODE = 2'd1;
        tick();
        CFG_WE = 1'b0;
        chk("idle_cfg_mode_pre", 32'(MODE), 32'd3);
        push(8'h77, 1'b0);
        chk("idle_cfg_mode", 32'(MODE), 32'd1);
        chk("idle_cfg_clr", 32'(RX_CLR), 32'd1);
        chk("apply_stb_ignored", 32'(LEVEL), 32'd0);

        // Idle timeout: none before first byte, one pulse after
        do_reset();
        pulses = 0;
        repeat (40) begin
            tick();
            if (IDLE_TO) pulses++;
        end
        chk("idle_no_prebyte", 32'(pulses), 32'd0);
        push(8'h42, 1'b0);
        pulses = 0;
        first_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (IDLE_TO) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
        chk("idle_latency", 32'(first_at), 32'(TIMEOUT - 1));
        chk("idle_once", 32'(pulses), 32'd1);

        // SCLR mid-operation with data and a pending config
        do_reset();
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b0);
        RX_BUSY = 1'b1;
        CFG_WE = 1'b1; CFG_MODE = 2'd2;
        tick();
        CFG_WE = 1'b0;
        chk("pre_sclr_level", 32'(LEVEL), 32'd5);
        SCLR = 1'b1;
        RX_BUSY = 1'b0;
        tick();
        chk_reset_vals("sclr");
        SCLR = 1'b0;
        tick();
        chk("post_sclr_mode", 32'(MODE), 32'd0);
        chk("post_sclr_clr", 32'(RX_CLR), 32'd0);
        chk("post_sclr_dvalid", 32'(DVALID), 32'd0);
        tick();
        chk("post_sclr_mode2", 32'(MODE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller between the UART receiver and its byte consumer. Owns the receiver's baud-mode configuration and applies changes only between frames. Buffers received bytes in a first-word-fall-through FIFO behind a valid/ready port. Tracks framing errors, overruns and inter-byte idle timeouts.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- TIMEOUT, 1024, SCLK cycles of line silence after the last accepted byte before IDLE_TO pulses; ≥2
- SCLK  in  1  system clock; all logic on the rising edge
- SCLR  in  1  reset, synchronous, active-high
- CFG_WE  in  1  one-cycle request to load CFG_MODE
- CFG_MODE  in  2  requested baud mode
- MODE  out  2  baud mode driven to the receiver and baud generator
- RX_CLR  out  1  one-cycle clear to the receiver when MODE changes
- RX_BUSY  in  1  receiver is mid-frame (start bit seen, stop bit not yet done)
- RX_STB  in  1  one-cycle strobe: frame complete
- RX_BYTE  in  8  received byte, valid with RX_STB
- RX_ERR  in  1  stop-bit error, valid with RX_STB
- DOUT  out  8  FIFO head byte
- DVALID  out  1  FIFO not empty
- DREADY  in  1  consumer accepts DOUT
- LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
- OVERRUN  out  1  sticky: a good byte was dropped because the FIFO was full
- ERR_CNT  out  8  framing errors, saturating at 255
- IDLE_TO  out  1  one-cycle idle-timeout pulse
- CLR_STAT  in  1  clears OVERRUN and ERR_CNT

## Operation
- Config FSM states: RUN, PEND, APPLY.
  - RUN + CFG_WE + !RX_BUSY -> APPLY; CFG_MODE is latched.
  - RUN + CFG_WE + RX_BUSY -> PEND; CFG_MODE is latched.
  - PEND + !RX_BUSY -> APPLY.
  - PEND + CFG_WE -> stay in PEND; the latch is overwritten, so the last request wins.
  - APPLY: MODE <= latched value, RX_CLR = 1 for exactly this cycle, then -> RUN.
  - CFG_WE in APPLY is treated as a new RUN request on the following cycle.
- Byte intake on RX_STB:
  - RX_ERR = 1: byte discarded; ERR_CNT += 1, saturating at 255.
  - RX_ERR = 0 and FIFO not full, or full with a pop in the same cycle: byte pushed.
  - RX_ERR = 0, FIFO full and no pop: byte dropped; OVERRUN <= 1.
- RX_STB during APPLY is ignored; the receiver is being cleared.
- Pop on DVALID & DREADY. DREADY while DVALID = 0 has no effect.
- Push and pop in the same cycle: LEVEL unchanged; order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- CLR_STAT in the same cycle as an error or overrun event: the clear is applied first, then the event. Result: ERR_CNT = 1 or OVERRUN = 1.
- Idle counter:
  - Cleared on every pushed byte; increments while !RX_BUSY and no RX_STB.
  - Holds while RX_BUSY.
  - IDLE_TO pulses once when the counter reaches TIMEOUT-1, only if at least one byte has been pushed since the last pulse or reset.
  - The counter then stops until the next push, so there is no repeated pulse.

## Timing
- Reset values: MODE=0, RX_CLR=0, DOUT=0, DVALID=0, LEVEL=0, OVERRUN=0, ERR_CNT=0, IDLE_TO=0.
- Reset state: FSM=RUN, pointers=0, idle counter=0, armed flag=0.
- SCLR mid-operation: FIFO contents and any pending configuration are discarded; no RX_CLR pulse is issued.
- Push latency: RX_STB at edge N gives DVALID=1 and DOUT=byte after edge N+1.
- Pop: DOUT/DVALID show the next entry after the accepting edge.
- LEVEL and status outputs are registered and update on the same edge as the event.
- Config latency:
  - From idle: CFG_WE at edge N gives APPLY during cycle N+1, with MODE and RX_CLR visible after edge N+1.
  - From PEND: MODE updates one cycle after RX_BUSY falls.
- DOUT holds its value while DVALID & !DREADY.

## Test plan
- Reset, then 3 bytes 0xA5, 0x3C, 0xFF with RX_ERR=0, DREADY=0 -> LEVEL=3, DOUT=0xA5. Raise DREADY -> bytes read out in order, then DVALID=0.
- Fill DEPTH=8 with DREADY=0, push a 9th byte 0x55 -> dropped, OVERRUN=1, LEVEL=8. Repeat with a full FIFO and DREADY=1 in the same cycle -> 0x55 accepted, LEVEL stays 8, OVERRUN stays 0.
- 256 RX_STB with RX_ERR=1 -> ERR_CNT=255, FIFO empty. CLR_STAT together with one more error -> ERR_CNT=1.
- CFG_WE with CFG_MODE=2 while RX_BUSY=1; then CFG_WE with CFG_MODE=3; then drop RX_BUSY -> MODE=3, a single RX_CLR pulse, no change to MODE while busy.
- Push one byte, hold the line idle -> IDLE_TO pulses exactly TIMEOUT-1 cycles after the push, once only. No pulse before the first byte after reset.
- Assert SCLR with LEVEL=5 and a config request in PEND -> all outputs at their reset values, MODE=0 next cycle.
